// File: rtl/phy_pkg.sv
// phy_pkg
// Shared definitions for the PHY receive front end.
//   COM_SYM            : comma/idle symbol hunted for byte alignment
//   DEFAULT_LOCK_COUNT : aligned COMs needed before the link is declared active
//   rx_state_e         : alignment FSM states (also the encoding seen on state_o)
package phy_pkg;

    localparam logic [7:0] COM_SYM            = 8'hBC;
    localparam int         DEFAULT_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_rx_align_com_detect.sv
// com_detect
// Serial-to-byte window plus COM comparator.
//   clk_i    : bit clock, rising edge
//   rst_i    : synchronous active-high reset, clears the window
//   bit_i    : serial bit, MSB first
//   nxt_o    : byte completed by the current bit ({previous 7 bits, bit_i})
//   is_com_o : nxt_o equals COM
module com_detect #(
    parameter logic [7:0] COM = 8'hBC
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bit_i,
    output logic [7:0] nxt_o,
    output logic       is_com_o
);

    // Only the seven most recent bits need to be stored: the eighth bit of
    // every window is the live input, so the oldest bit of an 8-bit register
    // would never be read.
    logic [6:0] sr_q;

    assign nxt_o    = {sr_q, bit_i};
    assign is_com_o = (nxt_o == COM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= 7'd0;
        end else begin
            sr_q <= nxt_o[6:0];
        end
    end

endmodule

// File: rtl/serial_rx_align.sv
// serial_rx_align
// Serial receiver front end: hunts for COM at any bit offset, confirms
// alignment with LOCK_COUNT consecutive aligned COMs, then emits one byte
// every 8 bits as {valid, byte} with a one-cycle strobe.
//   clk16       : serial bit clock, rising edge
//   reset       : synchronous active-high reset, overrides every transition
//   serial_in   : serial data, MSB first, one bit per cycle
//   data_out    : {valid, byte}; valid is 0 when the byte is COM; held between strobes
//   data_strobe : one-cycle pulse, data_out updated this cycle
//   active      : link aligned and locked
//   state_o     : current alignment FSM state (rx_state_e encoding), for observation
//
// Handshake: data_strobe is a pure valid pulse with no back-pressure; the
// consumer must take data_out in the cycle data_strobe is high.
module serial_rx_align
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM        = COM_SYM,
    parameter int unsigned LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic       serial_in,
    output logic [8:0] data_out,
    output logic       data_strobe,
    output logic       active,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_SEARCH = SEARCH;
    localparam logic [1:0] ST_ALIGN  = ALIGN;
    localparam logic [1:0] ST_LOCKED = LOCKED;
    localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);

    logic [7:0] nxt;
    logic       is_com;

    logic [1:0] state_q,   state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [8:0] data_q,    data_d;
    logic       strobe_q,  strobe_d;
    logic       active_q,  active_d;
    logic       boundary;

    com_detect #(
        .COM (COM)
    ) u_com_detect (
        .clk_i    (clk16),
        .rst_i    (reset),
        .bit_i    (serial_in),
        .nxt_o    (nxt),
        .is_com_o (is_com)
    );

    // bit_cnt is zeroed on the cycle the first COM completes, so it reads 7
    // exactly when a later aligned byte completes.
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        active_d  = active_q;

        case (state_q)
            ST_SEARCH: begin
                // Free-running count is meaningless while hunting.
                bit_cnt_d = bit_cnt_q;
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_d  = ST_LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == LOCK_CNT) begin
                            state_d  = ST_LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        // The failing byte is dropped; hunting resumes on
                        // the next bit.
                        state_d   = ST_SEARCH;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    data_d   = {~is_com, nxt};
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk16) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 9'h000;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign data_out    = data_q;
    assign data_strobe = strobe_q;
    assign active      = active_q;
    assign state_o     = state_q;

endmodule
